// File: rtl/oser16_pkg.sv
// Shared definitions for the OSER16 lane controller.
//   link_state_e  : controller phase (OFF, SRST, SETTLE, TRAIN, RUN), 3 bits
//   *_PAT_DEF     : default training and filler words
//   cnt_width()   : phase-counter width for a given set of phase lengths
package oser16_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_SRST   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_TRAIN  = 3'd3,
        ST_RUN    = 3'd4
    } link_state_e;

    localparam logic [15:0] TRAIN_PAT_DEF = 16'h00FF;
    localparam logic [15:0] IDLE_PAT_DEF  = 16'h0000;

    // The counter is loaded with (length - 1), so $clog2 of the longest
    // phase is enough bits; a single-cycle phase still needs one bit.
    function automatic int cnt_width(input int rst_cycles,
                                     input int settle_cycles,
                                     input int train_words);
        int m;
        m = rst_cycles;
        if (settle_cycles > m) begin
            m = settle_cycles;
        end else begin
            m = m;
        end
        if (train_words > m) begin
            m = train_words;
        end else begin
            m = m;
        end
        if ($clog2(m) < 1) begin
            return 1;
        end else begin
            return $clog2(m);
        end
    endfunction

endpackage

// File: rtl/oser16_link_ctrl.sv
// PCLK-domain sequencer for one OSER16 serializer lane.
// Holds the serializer in reset, lets its pipeline fill with idle words,
// sends a training burst, then streams words from a valid/ready source,
// filling stalls with IDLE_PAT and counting them once streaming has begun.
//
// Ports:
//   PCLK       in   parallel-word clock (shared with OSER16 PCLK)
//   RESET      in   asynchronous active-high reset
//   ENABLE     in   lane enable; low forces OFF
//   TRAIN_REQ  in   retrain request level
//   S_DATA     in   upstream word, bit 0 serialized first
//   S_VALID    in   upstream word valid
//   S_READY    out  combinational accept strobe
//   SER_RESET  out  registered OSER16 RESET
//   SER_D      out  registered OSER16 D15..D0
//   LINK_UP    out  registered, high while in RUN
//   UNDER_CNT  out  registered saturating stall counter
module oser16_link_ctrl
    import oser16_pkg::*;
#(
    parameter int          RST_CYCLES    = 8,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          TRAIN_WORDS   = 64,
    parameter logic [15:0] TRAIN_PAT     = TRAIN_PAT_DEF,
    parameter logic [15:0] IDLE_PAT      = IDLE_PAT_DEF
) (
    input  logic        PCLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        TRAIN_REQ,
    input  logic [15:0] S_DATA,
    input  logic        S_VALID,
    output logic        S_READY,
    output logic        SER_RESET,
    output logic [15:0] SER_D,
    output logic        LINK_UP,
    output logic [15:0] UNDER_CNT
);

    localparam int CW = cnt_width(RST_CYCLES, SETTLE_CYCLES, TRAIN_WORDS);

    localparam logic [CW-1:0] RST_LOAD    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TRAIN_LOAD  = CW'(TRAIN_WORDS - 1);

    link_state_e   state_r;
    logic [CW-1:0] cnt_r;
    logic          streaming_r;
    logic          ser_reset_r;
    logic [15:0]   ser_d_r;
    logic          link_up_r;
    logic [15:0]   under_cnt_r;

    logic          s_ready_s;
    logic          transfer_s;

    assign s_ready_s  = (state_r == ST_RUN) && ENABLE && !TRAIN_REQ;
    assign transfer_s = S_VALID && s_ready_s;

    assign S_READY   = s_ready_s;
    assign SER_RESET = ser_reset_r;
    assign SER_D     = ser_d_r;
    assign LINK_UP   = link_up_r;
    assign UNDER_CNT = under_cnt_r;

    // Phase FSM: outputs are registered alongside the state they belong to,
    // so they change on the same edge the state is entered.
    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            state_r     <= ST_OFF;
            cnt_r       <= '0;
            streaming_r <= 1'b0;
            ser_reset_r <= 1'b1;
            ser_d_r     <= IDLE_PAT;
            link_up_r   <= 1'b0;
            under_cnt_r <= 16'h0000;
        end else if (!ENABLE) begin
            // UNDER_CNT is deliberately held: only RESET clears it.
            state_r     <= ST_OFF;
            cnt_r       <= '0;
            streaming_r <= 1'b0;
            ser_reset_r <= 1'b1;
            ser_d_r     <= IDLE_PAT;
            link_up_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_OFF: begin
                    state_r     <= ST_SRST;
                    cnt_r       <= RST_LOAD;
                    ser_reset_r <= 1'b1;
                    ser_d_r     <= IDLE_PAT;
                    link_up_r   <= 1'b0;
                end
                ST_SRST: begin
                    ser_d_r   <= IDLE_PAT;
                    link_up_r <= 1'b0;
                    if (cnt_r == '0) begin
                        state_r     <= ST_SETTLE;
                        cnt_r       <= SETTLE_LOAD;
                        ser_reset_r <= 1'b0;
                    end else begin
                        cnt_r       <= cnt_r - CW'(1);
                        ser_reset_r <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    ser_reset_r <= 1'b0;
                    link_up_r   <= 1'b0;
                    if (cnt_r == '0) begin
                        state_r <= ST_TRAIN;
                        cnt_r   <= TRAIN_LOAD;
                        ser_d_r <= TRAIN_PAT;
                    end else begin
                        cnt_r   <= cnt_r - CW'(1);
                        ser_d_r <= IDLE_PAT;
                    end
                end
                ST_TRAIN: begin
                    ser_reset_r <= 1'b0;
                    if (TRAIN_REQ) begin
                        // A request during training restarts the full burst.
                        cnt_r     <= TRAIN_LOAD;
                        ser_d_r   <= TRAIN_PAT;
                        link_up_r <= 1'b0;
                    end else if (cnt_r == '0) begin
                        state_r   <= ST_RUN;
                        ser_d_r   <= IDLE_PAT;
                        link_up_r <= 1'b1;
                    end else begin
                        cnt_r     <= cnt_r - CW'(1);
                        ser_d_r   <= TRAIN_PAT;
                        link_up_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    ser_reset_r <= 1'b0;
                    if (TRAIN_REQ) begin
                        state_r     <= ST_TRAIN;
                        cnt_r       <= TRAIN_LOAD;
                        ser_d_r     <= TRAIN_PAT;
                        link_up_r   <= 1'b0;
                        streaming_r <= 1'b0;
                    end else if (transfer_s) begin
                        ser_d_r     <= S_DATA;
                        streaming_r <= 1'b1;
                        link_up_r   <= 1'b1;
                    end else begin
                        ser_d_r   <= IDLE_PAT;
                        link_up_r <= 1'b1;
                        // Stalls only count once real data has flowed.
                        if (streaming_r && (under_cnt_r != 16'hFFFF)) begin
                            under_cnt_r <= under_cnt_r + 16'd1;
                        end else begin
                            under_cnt_r <= under_cnt_r;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_OFF;
                    cnt_r       <= '0;
                    streaming_r <= 1'b0;
                    ser_reset_r <= 1'b1;
                    ser_d_r     <= IDLE_PAT;
                    link_up_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oser16_link_ctrl.sv
`timescale 1ns/1ps
module tb_oser16_link_ctrl;
    import oser16_pkg::*;

    localparam logic [15:0] TP = 16'h00FF;
    localparam logic [15:0] IP = 16'h0000;

    logic        PCLK;
    logic        RESET;
    logic        ENABLE;
    logic        TRAIN_REQ;
    logic [15:0] S_DATA;
    logic        S_VALID;
    logic        S_READY;
    logic        SER_RESET;
    logic [15:0] SER_D;
    logic        LINK_UP;
    logic [15:0] UNDER_CNT;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    int          under_m;
    logic        streaming_m;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        tr;
        logic        exp_rdy;
    } vec_t;

    vec_t vecs[7];

    oser16_link_ctrl dut (
        .PCLK      (PCLK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .TRAIN_REQ (TRAIN_REQ),
        .S_DATA    (S_DATA),
        .S_VALID   (S_VALID),
        .S_READY   (S_READY),
        .SER_RESET (SER_RESET),
        .SER_D     (SER_D),
        .LINK_UP   (LINK_UP),
        .UNDER_CNT (UNDER_CNT)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_check();
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got SER_D %h with empty queue, required an entry", SER_D);
        end else begin
            e = exp_q.pop_front();
            chk("sb_ser_d", {16'h0, SER_D}, {16'h0, e});
        end
    endtask

    // Enable from OFF; edge 0 is the first edge sampling ENABLE=1.
    // Values are checked 1ns after each edge k.
    task automatic bringup(input int exp_under);
        @(negedge PCLK);
        ENABLE = 1'b1;
        for (int k = 0; k <= 76; k++) begin
            @(posedge PCLK);
            #1;
            chk("bu_ser_reset", {31'h0, SER_RESET}, {31'h0, (k <= 7) ? 1'b1 : 1'b0});
            chk("bu_ser_d", {16'h0, SER_D},
                {16'h0, ((k >= 12) && (k <= 75)) ? TP : IP});
            chk("bu_link_up", {31'h0, LINK_UP}, {31'h0, (k >= 76) ? 1'b1 : 1'b0});
            chk("bu_s_ready", {31'h0, S_READY}, {31'h0, (k >= 76) ? 1'b1 : 1'b0});
        end
        chk("bu_under", {16'h0, UNDER_CNT}, exp_under[31:0]);
    endtask

    initial begin
        vecs[0] = '{v: 1'b1, d: 16'hA5C3, tr: 1'b0, exp_rdy: 1'b1};
        vecs[1] = '{v: 1'b1, d: 16'h1234, tr: 1'b0, exp_rdy: 1'b1};
        vecs[2] = '{v: 1'b0, d: 16'hDEAD, tr: 1'b0, exp_rdy: 1'b1};
        vecs[3] = '{v: 1'b0, d: 16'hDEAD, tr: 1'b0, exp_rdy: 1'b1};
        vecs[4] = '{v: 1'b0, d: 16'hDEAD, tr: 1'b0, exp_rdy: 1'b1};
        vecs[5] = '{v: 1'b1, d: 16'h5A5A, tr: 1'b0, exp_rdy: 1'b1};
        vecs[6] = '{v: 1'b1, d: 16'h0F0F, tr: 1'b1, exp_rdy: 1'b0};

        RESET     = 1'b1;
        ENABLE    = 1'b0;
        TRAIN_REQ = 1'b0;
        S_DATA    = 16'h0000;
        S_VALID   = 1'b0;
        under_m     = 0;
        streaming_m = 1'b0;

        #12;
        chk("rst_ser_reset", {31'h0, SER_RESET}, 32'h1);
        chk("rst_ser_d", {16'h0, SER_D}, 32'h0);
        chk("rst_link_up", {31'h0, LINK_UP}, 32'h0);
        chk("rst_under", {16'h0, UNDER_CNT}, 32'h0);
        chk("rst_s_ready", {31'h0, S_READY}, 32'h0);

        @(negedge PCLK);
        RESET = 1'b0;
        bringup(0);

        // Table-driven RUN traffic with a scoreboard on SER_D.
        for (int i = 0; i < 7; i++) begin
            @(negedge PCLK);
            S_VALID   = vecs[i].v;
            S_DATA    = vecs[i].d;
            TRAIN_REQ = vecs[i].tr;
            #1;
            chk("vec_s_ready", {31'h0, S_READY}, {31'h0, vecs[i].exp_rdy});
            if (vecs[i].tr) begin
                exp_q.push_back(TP);
                streaming_m = 1'b0;
            end else if (vecs[i].v) begin
                exp_q.push_back(vecs[i].d);
                streaming_m = 1'b1;
            end else begin
                exp_q.push_back(IP);
                if (streaming_m && (under_m < 65535)) under_m++;
            end
            @(posedge PCLK);
            #1;
            sb_check();
            chk("vec_under", {16'h0, UNDER_CNT}, under_m[31:0]);
            chk("vec_link_up", {31'h0, LINK_UP}, {31'h0, ~vecs[i].tr});
        end
        chk("under_after_gap", {16'h0, UNDER_CNT}, 32'd3);

        // Held word waits through the retrain burst.
        @(negedge PCLK);
        TRAIN_REQ = 1'b0;
        S_VALID   = 1'b1;
        S_DATA    = 16'hBEEF;
        #1;
        chk("train_s_ready", {31'h0, S_READY}, 32'h0);
        for (int j = 1; j <= 63; j++) begin
            @(posedge PCLK);
            #1;
            chk("train_ser_d", {16'h0, SER_D}, {16'h0, TP});
            chk("train_link_up", {31'h0, LINK_UP}, 32'h0);
        end
        @(posedge PCLK);
        #1;
        chk("rerun_link_up", {31'h0, LINK_UP}, 32'h1);
        chk("rerun_ser_d", {16'h0, SER_D}, {16'h0, IP});
        chk("rerun_s_ready", {31'h0, S_READY}, 32'h1);
        exp_q.push_back(16'hBEEF);
        streaming_m = 1'b1;
        @(posedge PCLK);
        #1;
        sb_check();
        chk("rerun_under", {16'h0, UNDER_CNT}, under_m[31:0]);

        // Long stall drives the counter into saturation.
        @(negedge PCLK);
        S_VALID = 1'b0;
        repeat (70000) @(posedge PCLK);
        #1;
        under_m = (under_m + 70000 > 65535) ? 65535 : under_m + 70000;
        chk("under_sat", {16'h0, UNDER_CNT}, under_m[31:0]);
        chk("sat_ser_d", {16'h0, SER_D}, {16'h0, IP});

        // ENABLE drop in the middle of a training burst.
        @(negedge PCLK);
        TRAIN_REQ = 1'b1;
        @(negedge PCLK);
        TRAIN_REQ = 1'b0;
        repeat (5) @(posedge PCLK);
        #1;
        chk("mid_train_ser_d", {16'h0, SER_D}, {16'h0, TP});
        @(negedge PCLK);
        ENABLE = 1'b0;
        @(posedge PCLK);
        #1;
        chk("off_ser_reset", {31'h0, SER_RESET}, 32'h1);
        chk("off_link_up", {31'h0, LINK_UP}, 32'h0);
        chk("off_ser_d", {16'h0, SER_D}, {16'h0, IP});
        chk("off_under_held", {16'h0, UNDER_CNT}, under_m[31:0]);
        @(posedge PCLK);
        #1;
        chk("off_stay", {31'h0, SER_RESET}, 32'h1);
        bringup(under_m);

        // Asynchronous reset between edges while streaming.
        @(negedge PCLK);
        S_VALID = 1'b1;
        S_DATA  = 16'h1111;
        @(posedge PCLK);
        #1;
        chk("pre_rst_ser_d", {16'h0, SER_D}, 32'h1111);
        @(negedge PCLK);
        S_VALID = 1'b0;
        @(posedge PCLK);
        #3;
        RESET = 1'b1;
        #1;
        chk("arst_ser_reset", {31'h0, SER_RESET}, 32'h1);
        chk("arst_under", {16'h0, UNDER_CNT}, 32'h0);
        chk("arst_link_up", {31'h0, LINK_UP}, 32'h0);
        chk("arst_ser_d", {16'h0, SER_D}, {16'h0, IP});
        chk("arst_s_ready", {31'h0, S_READY}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
